// File: rtl/divisor_seq.sv
`default_nettype none
// ============================================================================
// Module      : divisor_seq
// Description : Sequential unsigned restoring divider, one quotient bit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_seq #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int             CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  C_CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_busy;
    logic             r_done;
    logic             r_divzero;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_q_next;

    // A kept partial remainder is always below the divisor, so WIDTH bits hold it.
    assign w_shift  = {r_r, r_q[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_d};
    assign w_fits   = ~w_trial[WIDTH];
    assign w_r_next = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_q_next = {r_q[WIDTH-2:0], w_fits};

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_d       <= '0;
            r_r       <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (Start) begin
                        if (Divisor == '0) begin
                            r_quot    <= '1;
                            r_rem     <= Dividend;
                            r_divzero <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= S_FIN;
                        end else begin
                            r_d     <= Divisor;
                            r_r     <= '0;
                            r_q     <= Dividend;
                            r_cnt   <= C_CNT_LAST;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - C_CNT_ONE;
                    if (r_cnt == '0) begin
                        r_quot    <= w_q_next;
                        r_rem     <= w_r_next;
                        r_divzero <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_FIN;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Quotient  = r_quot;
    assign Remainder = r_rem;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign DivZero   = r_divzero;

endmodule
`default_nettype wire

// File: tb/tb_divisor_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divisor_seq
// Description : Self-checking bench for divisor_seq (vectors + random model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divisor_seq;

    localparam int W   = 16;
    localparam int LAT = W + 1;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Busy;
    logic         Done;
    logic         DivZero;

    int n_cmp;
    int n_err;
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs[7];

    divisor_seq #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .Busy     (Busy),
        .Done     (Done),
        .DivZero  (DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; the request is sampled on the following rising edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        Start    = 1'b1;
        Dividend = a;
        Divisor  = b;
        @(negedge Clk);
        Start    = 1'b0;
        Dividend = W'($urandom);
        Divisor  = W'($urandom);
    endtask

    // c0 = cycles already elapsed since the accepting edge at entry.
    task automatic wait_done(input string name, input int c0, input int lat,
                             input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int cyc;
        int busy_cnt;
        int hold_bad;
        cyc      = c0;
        busy_cnt = 0;
        hold_bad = 0;
        while (!Done && cyc < 40) begin
            if (Busy) busy_cnt++;
            if (Quotient !== prev_q || Remainder !== prev_r) hold_bad++;
            @(negedge Clk);
            cyc++;
        end
        check({name, "_done_seen"}, 32'(Done), 32'd1);
        check({name, "_latency"},   32'(cyc), 32'(lat));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - c0));
        check({name, "_hold"},      32'(hold_bad), 32'd0);
        check({name, "_quot"},      32'(Quotient), 32'(eq));
        check({name, "_rem"},       32'(Remainder), 32'(er));
        check({name, "_divzero"},   32'(DivZero), 32'(edz));
        check({name, "_busy_at_done"}, 32'(Busy), 32'd0);
        prev_q = eq;
        prev_r = er;
    endtask

    task automatic done_drops(input string name);
        @(negedge Clk);
        check({name, "_done_pulse"}, 32'(Done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        int           late_done;

        n_cmp    = 0;
        n_err    = 0;
        prev_q   = '0;
        prev_r   = '0;
        Reset    = 1'b0;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;

        vecs[0] = '{16'd100,   16'd7,      16'd14,     16'd2,    1'b0};
        vecs[1] = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,    1'b0};
        vecs[2] = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,    1'b0};
        vecs[3] = '{16'd5,     16'd9,      16'd0,      16'd5,    1'b0};
        vecs[4] = '{16'd0,     16'd3,      16'd0,      16'd0,    1'b0};
        vecs[5] = '{16'd1234,  16'd0,      16'hFFFF,   16'd1234, 1'b1};
        vecs[6] = '{16'd10,    16'd3,      16'd3,      16'd1,    1'b0};

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_quot", 32'(Quotient), 32'd0);
        check("rst_rem",  32'(Remainder), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_dz",   32'(DivZero), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            accept(vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), 1, (vecs[i].b == '0) ? 1 : LAT,
                      vecs[i].q, vecs[i].r, vecs[i].dz);
            done_drops($sformatf("vec%0d", i));
        end

        // Start while busy is ignored, then a back-to-back start in the FIN cycle
        accept(16'd1000, 16'd10);
        repeat (4) @(negedge Clk);
        accept(16'd9, 16'd2);
        wait_done("busy_start", 6, LAT, 16'd100, 16'd0, 1'b0);
        accept(16'd9, 16'd2);
        wait_done("b2b", 1, LAT, 16'd4, 16'd1, 1'b0);
        done_drops("b2b");

        // Reset pulse confined between edges must not disturb a running op
        accept(16'd40000, 16'd123);
        #1 Reset = 1'b0;
        #2 Reset = 1'b1;
        wait_done("rst_glitch", 1, LAT, 16'd325, 16'd25, 1'b0);
        done_drops("rst_glitch");

        // Reset mid-operation aborts with no Done
        accept(16'd50000, 16'd7);
        repeat (8) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_quot", 32'(Quotient), 32'd0);
        check("abort_rem",  32'(Remainder), 32'd0);
        check("abort_dz",   32'(DivZero), 32'd0);
        Reset = 1'b1;
        late_done = 0;
        repeat (25) begin
            @(negedge Clk);
            if (Done || Busy) late_done++;
        end
        check("abort_no_done", 32'(late_done), 32'd0);
        prev_q = '0;
        prev_r = '0;

        // Randomized operations against an arithmetic model
        for (int i = 0; i < 60; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = 16'hFFFF;
                3:       begin b = W'($urandom); a = W'($urandom_range(0, 300)); end
                default: b = W'($urandom);
            endcase
            mq = (b == '0) ? '1 : a / b;
            mr = (b == '0) ? a  : a % b;
            accept(a, b);
            wait_done($sformatf("rnd%0d", i), 1, (b == '0) ? 1 : LAT, mq, mr, (b == '0));
            if ($urandom_range(0, 1) == 0) done_drops($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divisor_seq.md
Name: divisor_seq

Overview:
- Sequential unsigned shift-subtract (restoring) divider; the inverse of the shift-add multiplier in the datapath.
- Serves the MIPS DIVU/DIV path. The CPU issues Start with operands and waits for Done.
- Produces Quotient and Remainder in WIDTH iteration cycles, at one quotient bit per cycle.
- Signed handling stays outside this block in the ALU control (sign fix-up).

Parameters:
- WIDTH, 16: operand, quotient and remainder width in bits.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clk.
- Start  input  1  request pulse. Sampled on the Clk edge; accepted only when Busy=0.
- Dividend  input  WIDTH  numerator. Sampled only on the accepting edge.
- Divisor  input  WIDTH  denominator. Sampled only on the accepting edge.
- Quotient  output  WIDTH  result quotient. Registered; holds until the next completion.
- Remainder  output  WIDTH  result remainder. Registered; holds until the next completion.
- Busy  output  1  high while iterating.
- Done  output  1  one-cycle pulse when new results are valid.
- DivZero  output  1  set with Done when Divisor was 0. Holds until the next completion.

Behaviour:
- Reset (Reset=0 at an edge):
  - State goes to IDLE.
  - Quotient=0, Remainder=0, Busy=0, Done=0, DivZero=0.
  - Iteration counter=0.
  - This applies in any state; an operation in progress is aborted with no Done.
- States: IDLE, RUN, FIN.
  - Busy=1 only in RUN.
  - Done=1 only in FIN.
- IDLE/FIN, Start=1, Divisor≠0:
  - Latch Divisor into register D.
  - Load partial remainder R=0 (WIDTH+1 bits) and quotient shifter Q=Dividend.
  - Set counter=WIDTH-1 and go to RUN.
- IDLE/FIN, Start=1, Divisor=0:
  - Go directly to FIN.
  - Quotient=all ones, Remainder=Dividend, DivZero=1.
  - Done is visible in the cycle after the accepting edge.
- IDLE/FIN, Start=0:
  - FIN goes to IDLE; IDLE stays in IDLE.
  - Outputs hold.
- RUN, each edge:
  - Shift {R,Q} left by 1; T = {R[WIDTH-1:0],Q[WIDTH-1]} - {0,D}, computed in WIDTH+1 bits.
  - If T is non-negative (MSB=0): R=T and Q[0]=1.
  - Otherwise: R is the shifted value and Q[0]=0.
  - Decrement the counter.
  - The edge that processes counter=0 commits Quotient=Q (final) and Remainder=R[WIDTH-1:0], clears DivZero and moves to FIN.
- Latency:
  - Start accepted at edge k: Busy=1 from edge k to edge k+WIDTH.
  - Done=1 for exactly the cycle after edge k+WIDTH.
  - Total is WIDTH+1 cycles from Start sample to Done visible.
- Start while Busy=1: ignored; operands are not resampled and the current operation is unaffected.
- Start during FIN: accepted (back-to-back). Done stays a single cycle and the next operation proceeds with the normal latency.
- Operand inputs may change freely after the accepting edge. Only the latched copies are used.
- Quotient and Remainder do not change during RUN; they still show the previous result.
- Invariant for Divisor≠0: Dividend = Quotient*Divisor + Remainder, with Remainder < Divisor.

Test Plan:
- WIDTH=16, reset then Start with 100/7 → Busy for 16 cycles; Done in cycle 17; Quotient=14, Remainder=2, DivZero=0.
- 0xFFFF/1 then 0xFFFF/0xFFFF → Q=0xFFFF R=0; then Q=1 R=0.
- 5/9 → Q=0 R=5. Then 0/3 → Q=0 R=0.
- 1234/0 → Done in the cycle after the accepting edge; Q=0xFFFF, R=1234, DivZero=1. A following 10/3 → Q=3 R=1 with DivZero=0.
- Start 1000/10, then pulse Start with 9/2 at iteration 5 → the second Start is ignored; Q=100 R=0. Then Start 9/2 in the FIN cycle → accepted; Q=4 R=1 after 17 more cycles.
- Start 50000/7, then Reset=0 at iteration 8 → the next cycle shows Busy=0, Done=0, Q=0, R=0, and no Done pulse afterwards. Reset with Reset=1 held low only between edges has no effect.
